// File: rtl/xbar_slave_arbiter.sv
// ---------------------------------------------------------------------------
// xbar_slave_arbiter
//
// Slave-side arbiter for one crossbar target. Read-address (AR) and
// write-address/write-data (AW/W) paths are arbitrated independently with
// their own round-robin pointers, and each direction is throttled by an
// outstanding-transaction counter.
//
// Ports
//   ACLK, ARESET            clock, synchronous active-high reset
//   ar_req, aw_req          per-master address requests for this slave
//   ARREADY_S, AWREADY_S    slave address-channel ready
//   WREADY_S, WLAST_S       W beat acceptance / last beat of the open burst
//   RVALID_S/RREADY_S/RLAST_S  R handshake observation (read completion)
//   BVALID_S/BREADY_S       B handshake observation (write completion)
//   ar_grant, ar_sel, ARVALID_S   registered AR grant (one-hot, index, valid)
//   aw_grant, aw_sel, AWVALID_S   registered AW grant (one-hot, index, valid)
//   w_sel, w_active         owner of the W channel and its open flag
//   rd_count, wr_count      outstanding read / write transactions
//   count_err               sticky flag: completion seen with count at zero
// ---------------------------------------------------------------------------
module xbar_slave_arbiter #(
  parameter int MASTERS           = 2,
  parameter int MAX_OUTSTANDING   = 4,
  parameter int i_am_slave_number = 0,
  localparam int SW = $clog2(MASTERS),
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic [MASTERS-1:0] ar_req,
  input  logic [MASTERS-1:0] aw_req,
  input  logic               ARREADY_S,
  input  logic               AWREADY_S,
  input  logic               WREADY_S,
  input  logic               WLAST_S,
  input  logic               RVALID_S,
  input  logic               RREADY_S,
  input  logic               RLAST_S,
  input  logic               BVALID_S,
  input  logic               BREADY_S,
  output logic [MASTERS-1:0] ar_grant,
  output logic [SW-1:0]      ar_sel,
  output logic               ARVALID_S,
  output logic [MASTERS-1:0] aw_grant,
  output logic [SW-1:0]      aw_sel,
  output logic               AWVALID_S,
  output logic [SW-1:0]      w_sel,
  output logic               w_active,
  output logic [CW-1:0]      rd_count,
  output logic [CW-1:0]      wr_count,
  output logic               count_err
);

  // Elaboration-time parameter sanity checks.
  if (MASTERS < 2) begin : g_bad_masters
    $error("xbar_slave_arbiter: MASTERS must be at least 2");
  end
  if (MAX_OUTSTANDING < 1) begin : g_bad_max_out
    $error("xbar_slave_arbiter: MAX_OUTSTANDING must be at least 1");
  end
  if (i_am_slave_number < 0) begin : g_bad_slave_id
    $error("xbar_slave_arbiter: i_am_slave_number must be non-negative");
  end

  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
  // Pointer reset value: "last winner" = MASTERS-1 gives master 0 top priority.
  localparam logic [SW-1:0] LAST_RST = SW'(MASTERS - 1);

  typedef enum logic {
    AR_IDLE,
    AR_GRANT
  } ar_state_e;

  typedef enum logic [1:0] {
    AW_IDLE,
    AW_GRANT,
    W_DATA
  } aw_state_e;

  // Round-robin pick: search starts at last+1 and wraps modulo MASTERS.
  function automatic logic [SW-1:0] rr_pick(input logic [MASTERS-1:0] req,
                                            input logic [SW-1:0]      last);
    logic [SW-1:0] win;
    logic          found;
    int            idx;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= MASTERS; k++) begin
      idx = int'(last) + k;
      if (idx >= MASTERS) idx = idx - MASTERS;
      if (!found && req[idx]) begin
        win   = SW'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [MASTERS-1:0] onehot(input logic [SW-1:0] sel);
    return MASTERS'(1) << sel;
  endfunction

  // Saturating up/down counter step; simultaneous inc and dec cancel.
  function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] cnt,
                                             input logic          inc,
                                             input logic          dec);
    logic [CW-1:0] nxt;
    nxt = cnt;
    if (inc && !dec) begin
      if (cnt != MAX_CNT) nxt = cnt + 1'b1;
    end else if (dec && !inc) begin
      if (cnt != '0) nxt = cnt - 1'b1;
    end
    return nxt;
  endfunction

  function automatic logic cnt_underflow(input logic [CW-1:0] cnt,
                                         input logic          inc,
                                         input logic          dec);
    return dec && !inc && (cnt == '0);
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  ar_state_e          ar_state_q, ar_state_d;
  logic [MASTERS-1:0] ar_grant_q, ar_grant_d;
  logic [SW-1:0]      ar_sel_q,   ar_sel_d;
  logic [SW-1:0]      ar_last_q,  ar_last_d;

  aw_state_e          aw_state_q, aw_state_d;
  logic [MASTERS-1:0] aw_grant_q, aw_grant_d;
  logic [SW-1:0]      aw_sel_q,   aw_sel_d;
  logic [SW-1:0]      aw_last_q,  aw_last_d;
  logic [SW-1:0]      w_sel_q,    w_sel_d;

  logic [CW-1:0]      rd_count_q, rd_count_d;
  logic [CW-1:0]      wr_count_q, wr_count_d;
  logic               count_err_q, count_err_d;

  logic rd_inc, rd_dec, wr_inc, wr_dec;

  // ---------------------------------------------------------------------
  // AR arbitration
  // ---------------------------------------------------------------------
  always_comb begin
    ar_state_d = ar_state_q;
    ar_grant_d = ar_grant_q;
    ar_sel_d   = ar_sel_q;
    ar_last_d  = ar_last_q;
    case (ar_state_q)
      AR_IDLE: begin
        if ((|ar_req) && (rd_count_q < MAX_CNT)) begin
          ar_sel_d   = rr_pick(ar_req, ar_last_q);
          ar_grant_d = onehot(ar_sel_d);
          ar_state_d = AR_GRANT;
        end
      end
      AR_GRANT: begin
        // Grant is held even if the request drops; only ARREADY releases it.
        if (ARREADY_S) begin
          ar_last_d  = ar_sel_q;
          ar_grant_d = '0;
          ar_sel_d   = '0;
          ar_state_d = AR_IDLE;
        end
      end
      default: begin
        ar_grant_d = '0;
        ar_sel_d   = '0;
        ar_state_d = AR_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // AW arbitration and W channel ownership
  // ---------------------------------------------------------------------
  always_comb begin
    aw_state_d = aw_state_q;
    aw_grant_d = aw_grant_q;
    aw_sel_d   = aw_sel_q;
    aw_last_d  = aw_last_q;
    w_sel_d    = w_sel_q;
    case (aw_state_q)
      AW_IDLE: begin
        if ((|aw_req) && (wr_count_q < MAX_CNT)) begin
          aw_sel_d   = rr_pick(aw_req, aw_last_q);
          aw_grant_d = onehot(aw_sel_d);
          aw_state_d = AW_GRANT;
        end
      end
      AW_GRANT: begin
        if (AWREADY_S) begin
          aw_last_d  = aw_sel_q;
          w_sel_d    = aw_sel_q;
          aw_grant_d = '0;
          aw_sel_d   = '0;
          aw_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (WREADY_S && WLAST_S) begin
          w_sel_d    = '0;
          aw_state_d = AW_IDLE;
        end
      end
      default: begin
        aw_grant_d = '0;
        aw_sel_d   = '0;
        w_sel_d    = '0;
        aw_state_d = AW_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Outstanding counters
  // ---------------------------------------------------------------------
  always_comb begin
    rd_inc      = ARVALID_S & ARREADY_S;
    rd_dec      = RVALID_S & RREADY_S & RLAST_S;
    wr_inc      = AWVALID_S & AWREADY_S;
    wr_dec      = BVALID_S & BREADY_S;
    rd_count_d  = cnt_next(rd_count_q, rd_inc, rd_dec);
    wr_count_d  = cnt_next(wr_count_q, wr_inc, wr_dec);
    count_err_d = count_err_q
                | cnt_underflow(rd_count_q, rd_inc, rd_dec)
                | cnt_underflow(wr_count_q, wr_inc, wr_dec);
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ar_state_q  <= AR_IDLE;
      ar_grant_q  <= '0;
      ar_sel_q    <= '0;
      ar_last_q   <= LAST_RST;
      aw_state_q  <= AW_IDLE;
      aw_grant_q  <= '0;
      aw_sel_q    <= '0;
      aw_last_q   <= LAST_RST;
      w_sel_q     <= '0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
      count_err_q <= 1'b0;
    end else begin
      ar_state_q  <= ar_state_d;
      ar_grant_q  <= ar_grant_d;
      ar_sel_q    <= ar_sel_d;
      ar_last_q   <= ar_last_d;
      aw_state_q  <= aw_state_d;
      aw_grant_q  <= aw_grant_d;
      aw_sel_q    <= aw_sel_d;
      aw_last_q   <= aw_last_d;
      w_sel_q     <= w_sel_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
      count_err_q <= count_err_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs (all decoded directly from registered state)
  // ---------------------------------------------------------------------
  assign ar_grant  = ar_grant_q;
  assign ar_sel    = ar_sel_q;
  assign ARVALID_S = (ar_state_q == AR_GRANT);
  assign aw_grant  = aw_grant_q;
  assign aw_sel    = aw_sel_q;
  assign AWVALID_S = (aw_state_q == AW_GRANT);
  assign w_sel     = w_sel_q;
  assign w_active  = (aw_state_q == W_DATA);
  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;
  assign count_err = count_err_q;

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// ---------------------------------------------------------------------------
// tb_xbar_slave_arbiter
//
// Bench for xbar_slave_arbiter (MASTERS=2, MAX_OUTSTANDING=4). A behavioural
// model tracks "who holds the address grant", "who owns the W burst" and the
// outstanding counts as plain integers; a compare process checks every DUT
// output against it after each rising edge. Directed scenarios with literal
// expectations are followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_xbar_slave_arbiter;

  localparam int MASTERS = 2;
  localparam int MAXO    = 4;
  localparam int SW      = $clog2(MASTERS);
  localparam int CW      = $clog2(MAXO + 1);

  logic               ACLK;
  logic               ARESET;
  logic [MASTERS-1:0] ar_req, aw_req;
  logic               ARREADY_S, AWREADY_S, WREADY_S, WLAST_S;
  logic               RVALID_S, RREADY_S, RLAST_S, BVALID_S, BREADY_S;
  logic [MASTERS-1:0] ar_grant, aw_grant;
  logic [SW-1:0]      ar_sel, aw_sel, w_sel;
  logic               ARVALID_S, AWVALID_S, w_active, count_err;
  logic [CW-1:0]      rd_count, wr_count;

  xbar_slave_arbiter #(
    .MASTERS(MASTERS),
    .MAX_OUTSTANDING(MAXO),
    .i_am_slave_number(3)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ar_req(ar_req), .aw_req(aw_req),
    .ARREADY_S(ARREADY_S), .AWREADY_S(AWREADY_S),
    .WREADY_S(WREADY_S), .WLAST_S(WLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S), .RLAST_S(RLAST_S),
    .BVALID_S(BVALID_S), .BREADY_S(BREADY_S),
    .ar_grant(ar_grant), .ar_sel(ar_sel), .ARVALID_S(ARVALID_S),
    .aw_grant(aw_grant), .aw_sel(aw_sel), .AWVALID_S(AWVALID_S),
    .w_sel(w_sel), .w_active(w_active),
    .rd_count(rd_count), .wr_count(wr_count), .count_err(count_err)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_ar_busy;            // an AR grant is being presented
  int m_ar_own, m_ar_last;
  int m_aw_ph;              // 0: no AW activity, 1: AW presented, 2: W burst open
  int m_aw_own, m_aw_last;
  int m_rd, m_wr;
  bit m_err;
  bit ar_hs, aw_hs, r_done, b_done;

  function automatic int rr_pick(input logic [MASTERS-1:0] req, input int last);
    for (int k = 1; k <= MASTERS; k++)
      if (req[(last + k) % MASTERS]) return (last + k) % MASTERS;
    return 0;
  endfunction

  always @(posedge ACLK) begin
    if (ARESET) begin
      m_ar_busy = 0; m_ar_own = 0; m_ar_last = MASTERS - 1;
      m_aw_ph   = 0; m_aw_own = 0; m_aw_last = MASTERS - 1;
      m_rd = 0; m_wr = 0; m_err = 0;
    end else begin
      ar_hs  = m_ar_busy && ARREADY_S;
      aw_hs  = (m_aw_ph == 1) && AWREADY_S;
      r_done = RVALID_S && RREADY_S && RLAST_S;
      b_done = BVALID_S && BREADY_S;

      if (!m_ar_busy) begin
        if (ar_req != 0 && m_rd < MAXO) begin
          m_ar_own = rr_pick(ar_req, m_ar_last); m_ar_busy = 1;
        end
      end else if (ARREADY_S) begin
        m_ar_busy = 0; m_ar_last = m_ar_own;
      end

      if (m_aw_ph == 0) begin
        if (aw_req != 0 && m_wr < MAXO) begin
          m_aw_own = rr_pick(aw_req, m_aw_last); m_aw_ph = 1;
        end
      end else if (m_aw_ph == 1) begin
        if (AWREADY_S) begin m_aw_ph = 2; m_aw_last = m_aw_own; end
      end else if (WREADY_S && WLAST_S) begin
        m_aw_ph = 0;
      end

      if (ar_hs && !r_done) m_rd = (m_rd < MAXO) ? m_rd + 1 : m_rd;
      else if (r_done && !ar_hs) begin
        if (m_rd == 0) m_err = 1; else m_rd = m_rd - 1;
      end
      if (aw_hs && !b_done) m_wr = (m_wr < MAXO) ? m_wr + 1 : m_wr;
      else if (b_done && !aw_hs) begin
        if (m_wr == 0) m_err = 1; else m_wr = m_wr - 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge ACLK) begin
    #2;
    if (chk_en) begin
      chk("ar_grant",  ar_grant,  m_ar_busy ? (1 << m_ar_own) : 0);
      chk("ar_sel",    ar_sel,    m_ar_busy ? m_ar_own : 0);
      chk("ARVALID_S", ARVALID_S, m_ar_busy);
      chk("aw_grant",  aw_grant,  (m_aw_ph == 1) ? (1 << m_aw_own) : 0);
      chk("aw_sel",    aw_sel,    (m_aw_ph == 1) ? m_aw_own : 0);
      chk("AWVALID_S", AWVALID_S, m_aw_ph == 1);
      chk("w_active",  w_active,  m_aw_ph == 2);
      chk("w_sel",     w_sel,     (m_aw_ph == 2) ? m_aw_own : 0);
      chk("rd_count",  rd_count,  m_rd);
      chk("wr_count",  wr_count,  m_wr);
      chk("count_err", count_err, m_err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_inputs();
    ar_req = '0; aw_req = '0;
    ARREADY_S = 0; AWREADY_S = 0; WREADY_S = 0; WLAST_S = 0;
    RVALID_S = 0; RREADY_S = 0; RLAST_S = 0; BVALID_S = 0; BREADY_S = 0;
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    clear_inputs();
    ARESET = 1;
    @(negedge ACLK);
    ARESET = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_g, n_w;
    clear_inputs();
    ARESET = 1;
    @(negedge ACLK);
    ARESET = 0;
    chk_en = 1;

    // Reset values
    chk("rst_ar_grant", ar_grant, 0);
    chk("rst_aw_grant", aw_grant, 0);
    chk("rst_w_active", w_active, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_count_err", count_err, 0);

    // Both masters requesting AR, slave always ready: grant every 2 cycles,
    // alternating M0/M1, until 4 are outstanding.
    do_reset();
    ar_req = 2'b11; ARREADY_S = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge ACLK);
      chk("rr_arvalid", ARVALID_S, (i % 2 == 0) ? 1 : 0);
      if (i % 2 == 0) chk("rr_grant", ar_grant, ((i / 2) % 2 == 0) ? 1 : 2);
    end
    chk("max_rd_count", rd_count, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      chk("max_no_grant", ARVALID_S, 0);
    end
    RVALID_S = 1; RREADY_S = 1; RLAST_S = 1;
    @(negedge ACLK);
    RVALID_S = 0; RREADY_S = 0; RLAST_S = 0;
    chk("after_rlast_count", rd_count, 3);
    chk("after_rlast_novld", ARVALID_S, 0);
    @(negedge ACLK);
    chk("regrant_vld", ARVALID_S, 1);
    chk("regrant_m0", ar_grant, 1);
    @(negedge ACLK);
    ar_req = 0;
    chk("refill_count", rd_count, 4);

    // Simultaneous AR handshake and RLAST at rd_count=2
    do_reset();
    ar_req = 2'b01; ARREADY_S = 1;
    repeat (4) @(negedge ACLK);
    chk("two_reads", rd_count, 2);
    ARREADY_S = 0;
    @(negedge ACLK);
    chk("simul_grant", ARVALID_S, 1);
    ar_req = 0; ARREADY_S = 1; RVALID_S = 1; RREADY_S = 1; RLAST_S = 1;
    @(negedge ACLK);
    clear_inputs();
    chk("simul_count", rd_count, 2);
    chk("simul_noerr", count_err, 0);

    // B handshake at wr_count=0 sets sticky error
    do_reset();
    BVALID_S = 1; BREADY_S = 1;
    @(negedge ACLK);
    clear_inputs();
    chk("under_wr_count", wr_count, 0);
    chk("under_err", count_err, 1);
    repeat (3) @(negedge ACLK);
    chk("under_err_sticky", count_err, 1);
    do_reset();
    chk("err_cleared", count_err, 0);

    // AW from M1, AWREADY 3 cycles after grant, 4-beat W burst
    aw_req = 2'b10;
    n_g = 0; n_w = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge ACLK);
      if (aw_grant == 2'b10 && AWVALID_S) n_g++;
      if (w_active && w_sel == 1) n_w++;
      if (k == 9) chk("w_closed", w_active, 0);
      AWREADY_S = (k == 4);
      if (k == 4) aw_req = '0;
      WREADY_S = (k >= 5 && k <= 8);
      WLAST_S  = (k == 8);
    end
    chk("aw_grant_cycles", n_g, 4);
    chk("w_active_cycles", n_w, 4);
    chk("wr_count_one", wr_count, 1);

    // Reset in the middle of a W burst
    do_reset();
    aw_req = 2'b01; AWREADY_S = 1;
    @(negedge ACLK);
    aw_req = 0;
    @(negedge ACLK);
    chk("mid_w_active", w_active, 1);
    ARESET = 1;
    @(negedge ACLK);
    ARESET = 0;
    chk("rst_mid_w_active", w_active, 0);
    chk("rst_mid_aw_grant", aw_grant, 0);
    chk("rst_mid_wr_count", wr_count, 0);
    chk("rst_mid_rd_count", rd_count, 0);
    aw_req = 2'b11; AWREADY_S = 0;
    @(negedge ACLK);
    chk("post_rst_m0", aw_grant, 1);

    // Randomized traffic, model-checked every cycle
    for (int c = 0; c < 3000; c++) begin
      @(negedge ACLK);
      ARESET    = ($urandom_range(0, 249) == 0);
      ar_req    = MASTERS'($urandom_range(0, 3));
      aw_req    = MASTERS'($urandom_range(0, 3));
      ARREADY_S = ($urandom_range(0, 2) != 0);
      AWREADY_S = ($urandom_range(0, 2) != 0);
      WREADY_S  = ($urandom_range(0, 2) != 0);
      WLAST_S   = ($urandom_range(0, 2) == 0);
      RVALID_S  = ($urandom_range(0, 1) == 0);
      RREADY_S  = ($urandom_range(0, 1) == 0);
      RLAST_S   = ($urandom_range(0, 2) == 0);
      BVALID_S  = ($urandom_range(0, 2) == 0);
      BREADY_S  = ($urandom_range(0, 1) == 0);
    end
    @(negedge ACLK);
    clear_inputs();
    ARESET = 0;
    repeat (2) @(negedge ACLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
